// File: rtl/bfly_2p_inv_pipe_if.sv
// Handshake and data bundle for the inverse 2-point butterfly.
// The master side supplies X/Y/Wi and consumes the recovered a/b results.
interface bfly_2p_inv_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [2*DATA_WIDTH-1:0] x_in;
    logic signed [2*DATA_WIDTH-1:0] y_in;
    logic signed [DATA_WIDTH-1:0]   w_in;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [2*DATA_WIDTH-1:0] a_out;
    logic signed [2*DATA_WIDTH-1:0] b_out;

    modport master (
        output in_valid, x_in, y_in, w_in, out_ready,
        input  in_ready, out_valid, a_out, b_out
    );

    modport slave (
        input  in_valid, x_in, y_in, w_in, out_ready,
        output in_ready, out_valid, a_out, b_out
    );
endinterface

// File: rtl/bfly_2p_inv_pipe.sv
// Three-stage inverse 2-point butterfly: a = (X+Y)>>>1, b = round(((X-Y)>>>1) * Wi).
// Define BFLY_INV_SAT_EN to clamp b_out on overflow; otherwise b_out wraps.
module bfly_2p_inv_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_FRAC    = DATA_WIDTH - 1
) (
    input  logic              clk,
    input  logic              rst,
    bfly_2p_inv_pipe_if.slave bus
);
    localparam int W2 = 2 * DATA_WIDTH;
    localparam int W3 = 3 * DATA_WIDTH;
    localparam logic signed [W3:0] RND = {{W3{1'b0}}, 1'b1} << (TW_FRAC - 1);

    logic                         en;
    logic                         v1;
    logic                         v2;
    logic signed [W2:0]           xe;
    logic signed [W2:0]           ye;
    logic signed [W2:0]           s1;
    logic signed [W2:0]           d1;
    logic signed [DATA_WIDTH-1:0] w1;
    logic signed [W2-1:0]         a2;
    logic signed [W3-1:0]         dh;
    logic signed [W3-1:0]         wx;
    logic signed [W3-1:0]         p2;
    logic signed [W3:0]           pr;
    logic signed [W2-1:0]         bq;

    // A single enable stalls every stage together, so bubbles never collapse.
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    assign xe = {bus.x_in[W2-1], bus.x_in};
    assign ye = {bus.y_in[W2-1], bus.y_in};
    assign dh = W3'(d1 >>> 1);
    assign wx = W3'(w1);
    assign pr = {p2[W3-1], p2} + RND;

`ifdef BFLY_INV_SAT_EN
    localparam int RW = W3 + 1 - TW_FRAC;

    logic signed [RW-1:0] r;
    logic                 ovf_pos;
    logic                 ovf_neg;

    // Overflow shows up as the bits above the result's sign bit disagreeing with it.
    assign r       = RW'(pr >>> TW_FRAC);
    assign ovf_pos = !r[RW-1] && (|r[RW-2:W2-1]);
    assign ovf_neg = r[RW-1] && !(&r[RW-2:W2-1]);

    always_comb begin
        bq = r[W2-1:0];
        if (ovf_pos)
            bq = {1'b0, {(W2-1){1'b1}}};
        else if (ovf_neg)
            bq = {1'b1, {(W2-1){1'b0}}};
    end
`else
    assign bq = W2'(pr >>> TW_FRAC);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            s1            <= '0;
            d1            <= '0;
            w1            <= '0;
            a2            <= '0;
            p2            <= '0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
            bus.out_valid <= 1'b0;
        end else if (en) begin
            s1            <= xe + ye;
            d1            <= xe - ye;
            w1            <= bus.w_in;
            v1            <= bus.in_valid;
            a2            <= W2'(s1 >>> 1);
            p2            <= dh * wx;
            v2            <= v1;
            bus.a_out     <= a2;
            bus.b_out     <= bq;
            bus.out_valid <= v2;
        end
    end
endmodule

// File: tb/tb_bfly_2p_inv_pipe.sv
// Self-checking bench for bfly_2p_inv_pipe: directed cases plus randomized traffic
// scored against an arithmetic model of the inverse butterfly.
module tb_bfly_2p_inv_pipe;
    localparam int DW = 16;
    localparam int TW = 15;
    localparam int W2 = 2 * DW;
    localparam longint MAXV = (longint'(1) << (W2 - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W2 - 1));

    typedef struct {
        logic signed [W2-1:0] a;
        logic signed [W2-1:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   drained = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bfly_2p_inv_pipe_if #(.DATA_WIDTH(DW)) bus ();

    bfly_2p_inv_pipe #(.DATA_WIDTH(DW), .TW_FRAC(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic longint floorDiv(longint n, longint d);
        longint q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0)))
            q = q - 1;
        return q;
    endfunction

    // a = floor((X+Y)/2); b = floor(floor((X-Y)/2) * Wi / 2^TW + 1/2), then wrap or clamp.
    function automatic exp_t model(longint x, longint y, longint w);
        exp_t   e;
        longint r;
        e.a = W2'(floorDiv(x + y, 2));
        r   = floorDiv(floorDiv(x - y, 2) * w + (longint'(1) << (TW - 1)), longint'(1) << TW);
`ifdef BFLY_INV_SAT_EN
        if (r > MAXV)
            r = MAXV;
        else if (r < MINV)
            r = MINV;
`endif
        e.b = W2'(r);
        return e;
    endfunction

    task automatic checkValue(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(longint x, longint y, longint w, logic v);
        bus.x_in     = W2'(x);
        bus.y_in     = W2'(y);
        bus.w_in     = DW'(w);
        bus.in_valid = v;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checkValue("spurious_out_valid", 64'(bus.out_valid), 0);
        end else begin
            e = sb.pop_front();
            checkValue("sb_a", bus.a_out, e.a);
            checkValue("sb_b", bus.b_out, e.b);
            drained++;
        end
    endtask

    // Score the transfers the next edge commits, then advance one cycle.
    task automatic tick();
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready)
                checkOutput();
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.x_in, bus.y_in, bus.w_in));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directedBeat(string tag, longint x, longint y, longint w, longint ea, longint eb);
        applyStimulus(x, y, w, 1'b1);
        tick();
        applyStimulus(0, 0, 0, 1'b0);
        tick();
        tick();
        checkValue({tag, "_valid"}, 64'(bus.out_valid), 1);
        checkValue({tag, "_a"}, bus.a_out, ea);
        checkValue({tag, "_b"}, bus.b_out, eb);
        tick();
        checkValue({tag, "_valid_drop"}, 64'(bus.out_valid), 0);
    endtask

    initial begin
        int     k;
        int     base;
        longint rx;
        longint ry;
        longint rw;

        rst           = 1'b1;
        bus.out_ready = 1'b1;
        applyStimulus(0, 0, 0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        checkValue("rst_out_valid", 64'(bus.out_valid), 0);
        checkValue("rst_a_out", bus.a_out, 0);
        checkValue("rst_b_out", bus.b_out, 0);
        #1;
        checkValue("rst_in_ready", 64'(bus.in_ready), 1);
        tick();

        directedBeat("basic", 150, 50, 32767, 100, 50);
        directedBeat("neg_tw_tie", 150, 50, -32768, 100, -50);
        directedBeat("odd_pos", 3, 0, 32767, 1, 1);
        directedBeat("odd_neg", -3, 0, 32767, -2, -2);
`ifdef BFLY_INV_SAT_EN
        directedBeat("overflow", MINV, MAXV, -32768, -1, MAXV);
`else
        directedBeat("overflow", MINV, MAXV, -32768, -1, MINV);
`endif

        // Five beats with a four-cycle downstream stall starting when the first result appears.
        base = drained;
        k    = 1;
        for (int c = 1; c <= 30; c++) begin
            if (k <= 5)
                applyStimulus(2 * k, 0, 32767, 1'b1);
            else
                applyStimulus(0, 0, 0, 1'b0);
            bus.out_ready = !(c >= 4 && c <= 7);
            #1;
            if (c == 4)
                checkValue("bp_out_valid_rise", 64'(bus.out_valid), 1);
            if (c >= 4 && c <= 7) begin
                checkValue("bp_in_ready_low", 64'(bus.in_ready), 0);
                checkValue("bp_hold_a", bus.a_out, 1);
                checkValue("bp_hold_b", bus.b_out, 1);
            end
            if (bus.out_valid && bus.out_ready)
                checkValue("bp_order", bus.a_out, drained - base + 1);
            if (bus.in_valid && bus.in_ready)
                k++;
            tick();
        end
        checkValue("bp_count", drained - base, 5);

        applyStimulus(10, 4, 32767, 1'b1);
        tick();
        applyStimulus(-8, 2, -32768, 1'b1);
        tick();
        applyStimulus(0, 0, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkValue("mid_rst_out_valid", 64'(bus.out_valid), 0);
            checkValue("mid_rst_a", bus.a_out, 0);
            checkValue("mid_rst_b", bus.b_out, 0);
            tick();
        end
        directedBeat("post_rst", 1000, -200, 16384, 400, 300);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                rx = MINV;
                ry = MAXV;
                rw = -32768;
            end else begin
                rx = longint'($signed($urandom));
                ry = longint'($signed($urandom));
                rw = longint'($signed(16'($urandom)));
            end
            applyStimulus(rx, ry, rw, $urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        applyStimulus(0, 0, 0, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++)
            tick();
        checkValue("drain_empty", sb.size(), 0);
        checkValue("drain_out_valid", 64'(bus.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bfly_2p_inv_pipe.md
Name: bfly_2p_inv_pipe

Overview:
- Pipelined inverse (decimation-in-frequency) 2-point butterfly that undoes the forward butterfly.
- Takes the forward sum/difference pair X = A + B*W and Y = A - B*W and returns a = (X+Y)/2 and b = ((X-Y)/2) * Wi.
- Wi is the inverse/conjugate twiddle in signed fixed point.
- Sits in the IFFT datapath of the 8-point FFT subsystem, consuming 2*DATA_WIDTH-wide butterfly words under a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, base sample width; data ports are 2*DATA_WIDTH wide, twiddle is DATA_WIDTH wide.
- TW_FRAC, DATA_WIDTH-1, fractional bits of w_in (Q1.TW_FRAC format).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts input this cycle.
- x_in  in  2*DATA_WIDTH  signed forward-butterfly sum output X.
- y_in  in  2*DATA_WIDTH  signed forward-butterfly difference output Y.
- w_in  in  DATA_WIDTH  signed inverse twiddle Wi, Q1.TW_FRAC.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- a_out  out  2*DATA_WIDTH  signed recovered A = (X+Y)>>>1.
- b_out  out  2*DATA_WIDTH  signed recovered term ((X-Y)>>>1)*Wi, rounded and rescaled.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset: all stage valid bits clear, and a_out, b_out, out_valid are 0. in_ready is 1 in the cycle after reset deasserts.
- Pipeline: 3 register stages. Latency is 3 cycles from accept (in_valid && in_ready) to out_valid, with no stalls. Throughput is 1 word/cycle.
- Global stall rule: en = !v3 || out_ready, where v3 = out_valid. in_ready = en, purely combinational from v3 and out_ready.
  - When en = 0, every stage holds, including bubbles; bubbles do not collapse.
- Stage 1 (on en):
  - s1 = x_in + y_in and d1 = x_in - y_in, each sign-extended to 2*DATA_WIDTH+1 bits, so there is no overflow.
  - w1 = w_in.
  - v1 = in_valid.
- Stage 2 (on en):
  - a2 = s1 >>> 1, truncated to 2*DATA_WIDTH. This always fits; it floors toward -inf.
  - dh = d1 >>> 1 (2*DATA_WIDTH bits, floor).
  - p2 = dh * w1 as a full 3*DATA_WIDTH signed product.
  - v2 = v1.
- Stage 3 (on en):
  - a_out = a2.
  - r = (p2 + 2^(TW_FRAC-1)) >>> TW_FRAC, i.e. round half toward +inf.
  - b_out = r reduced to 2*DATA_WIDTH per the Optional Feature.
  - out_valid = v2.
- Holding: a_out and b_out hold while out_valid && !out_ready. They also hold their last value when out_valid is 0; downstream must qualify with out_valid.
- Simultaneous accept at input and drain at output in the same cycle is legal and sustains full rate.
- Reset mid-operation: in-flight words are discarded with no partial output. out_valid is 0 on the next edge, regardless of out_ready.
- Input values are don't-care when in_valid is 0; they are registered but never marked valid.

Optional Feature:
- Macro: BFLY_INV_SAT_EN.
- Defined: if r exceeds the 2*DATA_WIDTH signed range, b_out clamps to +2^(2*DATA_WIDTH-1)-1 or -2^(2*DATA_WIDTH-1).
- Undefined: b_out is the low 2*DATA_WIDTH bits of r (two's-complement wrap).
- Overflow is only reachable when dh = -2^(2*DATA_WIDTH-1) and w_in = -2^(DATA_WIDTH-1). a_out is unaffected either way.

Test Plan (DATA_WIDTH=16, TW_FRAC=15, out_ready=1 unless stated):
- Basic: x=150, y=50, w=0x7FFF, one beat -> after 3 cycles out_valid=1, a_out=100, b_out=50; then out_valid=0.
- Negative twiddle and rounding tie: x=150, y=50, w=0x8000 -> a_out=100, b_out=-50 (p=-1638400, +16384, >>>15 = -50).
- Odd/negative flooring:
  - x=3, y=0, w=0x7FFF -> a_out=1, b_out=1.
  - x=-3, y=0, w=0x7FFF -> a_out=-2, b_out=-2.
- Overflow: x=0x80000000, y=0x7FFFFFFF, w=0x8000 -> a_out=-1.
  - With BFLY_INV_SAT_EN: b_out=0x7FFFFFFF.
  - Without it: b_out=0x80000000.
- Backpressure: stream 5 beats with values 1..5 (x=2k, y=0, w=0x7FFF); hold out_ready=0 from cycle 4 for 4 cycles.
  - in_ready drops in the cycle out_valid rises.
  - Outputs stay stable while stalled.
  - After release, results a_out=1..5 emerge in order with no loss or duplication.
- Reset mid-stream: accept 2 beats, assert rst for 1 cycle before either emerges -> out_valid stays 0, a_out=b_out=0.
  - A beat accepted after reset emerges 3 cycles later with a correct result.
